// File: rtl/p3p_pkg.sv
// Shared score types, limits and normaliser FSM state encoding.
package p3p_pkg;
  localparam int NUM_W = 16;
  typedef logic signed [NUM_W-1:0] num;
  localparam num NUM_MAX = {1'b0, {(NUM_W-1){1'b1}}};
  localparam num NUM_MIN = {1'b1, {(NUM_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, SCAN_RD, NORM_RD, NORM_WR, FINISH} norm_state_t;
endpackage

// File: rtl/score_normaliser_multi_sat_sub.sv
// Saturating best - cur: clamps to the positive limit, optionally to 0 below zero.
// Purely combinational, no backpressure.
module sat_sub #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] best,
  input  logic signed [W-1:0] cur,
  input  logic                clamp_neg,
  output logic signed [W-1:0] result
);
  localparam logic signed [W:0] MAXV = {2'b00, {(W-1){1'b1}}};

  logic signed [W:0] diff;

  assign diff = {best[W-1], best} - {cur[W-1], cur};

  always_comb begin
    result = diff[W-1:0];
    if (diff > MAXV) result = MAXV[W-1:0];
    else if (clamp_neg && diff[W]) result = '0;
  end
endmodule

// File: rtl/score_normaliser_multi.sv
// Rewrites N_SENONES SRAM scores as best - score; one access per granted+ready cycle,
// 2N+1 (ext) or 3N+1 (scan) cycles unstalled; holds state while grant or ready is low.
module score_normaliser_multi
  import p3p_pkg::*;
#(
  parameter int N_SENONES = 10,
  parameter int SCORE_W   = 16,
  parameter int ADDR_W    = 21,
  parameter int BASE_ADDR = 0,
  parameter int STRIDE    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start_norm,
  input  logic                      mode_scan,
  input  logic signed [SCORE_W-1:0] best_score,
  output logic                      bus_req,
  input  logic                      bus_grant,
  input  logic                      sram_ready,
  output logic [ADDR_W-1:0]         data_addr,
  output logic                      read_data,
  output logic                      write_data,
  output logic signed [SCORE_W-1:0] data_out,
  input  logic signed [SCORE_W-1:0] data_in,
  output logic                      busy,
  output logic signed [SCORE_W-1:0] best_out,
  output logic                      norm_done
);
  localparam int IDX_W = (N_SENONES > 1) ? $clog2(N_SENONES) : 1;
  localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

  norm_state_t state, state_nxt;
  logic [IDX_W-1:0]          idx;
  logic signed [SCORE_W-1:0] best_reg, cur, result;
  logic                      clamp_neg;
  logic                      xfer, last;
  logic [ADDR_W-1:0]         addr;

  assign xfer = bus_grant & sram_ready;
  assign last = (idx == IDX_W'(N_SENONES - 1));
  assign addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(STRIDE);

  sat_sub #(.W(SCORE_W)) u_sat (
    .best      (best_reg),
    .cur       (cur),
    .clamp_neg (clamp_neg),
    .result    (result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus_req    = 1'b0;
    read_data  = 1'b0;
    write_data = 1'b0;
    data_addr  = '0;
    data_out   = '0;
    norm_done  = 1'b0;
    case (state)
      IDLE:    if (start_norm) state_nxt = mode_scan ? SCAN_RD : NORM_RD;
      SCAN_RD: begin
        bus_req   = 1'b1;
        read_data = bus_grant;
        if (xfer && last) state_nxt = NORM_RD;
      end
      NORM_RD: begin
        bus_req   = 1'b1;
        read_data = bus_grant;
        if (xfer) state_nxt = NORM_WR;
      end
      NORM_WR: begin
        bus_req    = 1'b1;
        write_data = bus_grant;
        data_out   = result;
        if (xfer) state_nxt = last ? FINISH : NORM_RD;
      end
      FINISH: begin
        norm_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Address bus is parked at zero whenever no strobe is driven.
    if (read_data || write_data) data_addr = addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      best_reg  <= '0;
      cur       <= '0;
      clamp_neg <= 1'b0;
      busy      <= 1'b0;
      best_out  <= '0;
    end else begin
      case (state)
        IDLE: if (start_norm) begin
          idx       <= '0;
          busy      <= 1'b1;
          clamp_neg <= ~mode_scan;
          best_reg  <= mode_scan ? MOST_NEG : best_score;
        end
        SCAN_RD: if (xfer) begin
          if (data_in > best_reg) best_reg <= data_in;
          idx <= last ? '0 : idx + 1'b1;
        end
        NORM_RD: if (xfer) cur <= data_in;
        NORM_WR: if (xfer && !last) idx <= idx + 1'b1;
        FINISH: begin
          busy     <= 1'b0;
          best_out <= best_reg;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_score_normaliser_multi.sv
// Randomised bench for score_normaliser_multi with an SRAM model and a per-cycle access reference.
module tb_score_normaliser_multi;
  import p3p_pkg::*;

  localparam int N    = 4;
  localparam int BASE = 32'h100;

  logic        clk = 1'b0;
  logic        reset_n, start_norm, mode_scan, bus_grant, sram_ready;
  num          best_score, data_out, data_in, best_out;
  logic        bus_req, read_data, write_data, busy, norm_done;
  logic [20:0] data_addr;

  num mem [0:4095];
  bit g_pat [256];
  bit r_pat [256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign data_in = read_data ? mem[data_addr[11:0]] : '0;

  score_normaliser_multi #(
    .N_SENONES (N), .SCORE_W (16), .ADDR_W (21), .BASE_ADDR (BASE), .STRIDE (2)
  ) dut (
    .clk (clk), .reset_n (reset_n), .start_norm (start_norm), .mode_scan (mode_scan),
    .best_score (best_score), .bus_req (bus_req), .bus_grant (bus_grant),
    .sram_ready (sram_ready), .data_addr (data_addr), .read_data (read_data),
    .write_data (write_data), .data_out (data_out), .data_in (data_in), .busy (busy),
    .best_out (best_out), .norm_done (norm_done)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_req", bus_req, 0);
    chk("rst_rd", read_data, 0);
    chk("rst_wr", write_data, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_best", best_out, 0);
    chk("rst_done", norm_done, 0);
  endtask

  // kind 0: always granted/ready, 1: 3 ready stalls per access plus 2 ungranted cycles on 2nd write, 2: random
  task automatic build_pat(input int kind, input int nacc);
    int p = 0;
    for (int i = 0; i < 256; i++) begin
      g_pat[i] = 1'b1;
      r_pat[i] = 1'b1;
    end
    if (kind == 1) begin
      for (int a = 0; a < nacc; a++) begin
        if (a == 3) begin
          for (int j = 0; j < 2; j++) begin g_pat[p] = 1'b0; r_pat[p] = 1'b1; p++; end
        end
        for (int j = 0; j < 3; j++) begin g_pat[p] = 1'b1; r_pat[p] = 1'b0; p++; end
        p++;
      end
    end else if (kind == 2) begin
      for (int i = 0; i < 200; i++) begin
        g_pat[i] = ($urandom_range(0, 3) != 0);
        r_pat[i] = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic run(input bit m, input int b, input int vals[N], input int kind,
                     input bit busy_start, input bit abort);
    int  res [N];
    int  bu, nacc, t_last, k, ix;
    bit  acc_wr [16];
    int  acc_idx [16];
    bit  wr, g;

    bu = b;
    if (m) begin
      bu = vals[0];
      for (int i = 1; i < N; i++) if (vals[i] > bu) bu = vals[i];
    end
    for (int i = 0; i < N; i++) begin
      res[i] = bu - vals[i];
      if (res[i] > 32767) res[i] = 32767;
      if (res[i] < 0 && !m) res[i] = 0;
    end
    nacc = 0;
    if (m) for (int i = 0; i < N; i++) begin acc_wr[nacc] = 0; acc_idx[nacc] = i; nacc++; end
    for (int i = 0; i < N; i++) begin
      acc_wr[nacc] = 0; acc_idx[nacc] = i; nacc++;
      acc_wr[nacc] = 1; acc_idx[nacc] = i; nacc++;
    end
    build_pat(kind, nacc);
    t_last = 0;
    k = 0;
    for (int t = 1; t <= 256 && k < nacc; t++)
      if (g_pat[t-1] && r_pat[t-1]) begin
        k++;
        if (k == nacc) t_last = t;
      end
    for (int i = 0; i < N; i++) mem[BASE + 2*i] = num'(vals[i]);

    @(posedge clk); #1;
    start_norm = 1'b1; mode_scan = m; best_score = num'(b); bus_grant = 1'b0; sram_ready = 1'b0;
    @(posedge clk); #1;
    start_norm = 1'b0;
    best_score = num'($urandom);
    k = 0;
    for (int t = 1; t <= t_last + 1; t++) begin
      bus_grant  = (t <= t_last) ? g_pat[t-1] : 1'($urandom);
      sram_ready = (t <= t_last) ? r_pat[t-1] : 1'($urandom);
      if (busy_start && t == 3) begin
        start_norm = 1'b1; best_score = '0; mode_scan = ~m;
      end else start_norm = 1'b0;
      @(negedge clk);
      if (t <= t_last) begin
        wr = acc_wr[k]; ix = acc_idx[k]; g = bus_grant;
        chk("bus_req", bus_req, 1);
        chk("rd", read_data, !wr && g);
        chk("wr", write_data, wr && g);
        chk("addr", data_addr, g ? BASE + 2*ix : 0);
        chk("dout", data_out, wr ? res[ix] : 0);
        chk("done_early", norm_done, 0);
        chk("busy_run", busy, 1);
        if (write_data && bus_grant && sram_ready) mem[data_addr[11:0]] = data_out;
        if (abort && wr && ix == 2) begin
          #1 reset_n = 1'b0;
          #1 chk_all_zero();
          repeat (3) begin
            @(negedge clk);
            chk("abort_done", norm_done, 0);
            chk("abort_busy", busy, 0);
          end
          @(posedge clk); #1 reset_n = 1'b1;
          return;
        end
        if (bus_grant && sram_ready) k++;
      end else begin
        chk("done", norm_done, 1);
        chk("fin_req", bus_req, 0);
        chk("fin_rd", read_data, 0);
        chk("fin_wr", write_data, 0);
        chk("fin_busy", busy, 1);
      end
      @(posedge clk); #1;
    end
    start_norm = 1'b0;
    @(negedge clk);
    chk("done_pulse", norm_done, 0);
    chk("busy_end", busy, 0);
    chk("best_out", best_out, bu);
    for (int i = 0; i < N; i++) chk("mem", mem[BASE + 2*i], res[i]);
  endtask

  initial begin
    int v1 [N];
    int vs1 [N];
    int vs2 [N];
    int vr [N];
    v1  = '{-100, -250, -90, -400};
    vs1 = '{-32000, -100, 0, 32767};
    vs2 = '{-100, -600, -500, 200};
    reset_n = 1'b0; start_norm = 1'b0; mode_scan = 1'b0; best_score = '0;
    bus_grant = 1'b0; sram_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    #1 chk_all_zero();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run(0, -90, v1, 0, 0, 0);
    run(1, 0, v1, 0, 0, 0);
    run(0, 32000, vs1, 0, 0, 0);
    run(0, -500, vs2, 0, 0, 0);
    run(0, -90, v1, 1, 0, 0);
    run(0, -90, v1, 0, 1, 0);
    run(1, 0, v1, 2, 1, 0);
    run(0, -90, v1, 0, 0, 1);
    run(0, -90, v1, 0, 0, 0);
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N; i++) vr[i] = int'(num'($urandom));
      run(1'($urandom), int'(num'($urandom)), vr, 2, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
